// File: rtl/m68k_bus_ctrl.sv
// Clock-enable, reset stretcher and bus-cycle sequencer for an fx68k-based 68000 core.
// Produces enPhi1/enPhi2, a held CPU reset, wait-stated DTACK, autovector VPA and a BERR watchdog.
module m68k_bus_ctrl #(
   parameter int CLK_DIV      = 2,
   parameter int RST_HOLD     = 16,
   parameter int DTACK_WAIT   = 0,
   parameter int AUTOVEC      = 1,
   parameter int BERR_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        nRESET,
   output logic        en_phi1,
   output logic        en_phi2,
   output logic        cpu_reset,
   input  logic        nAS,
   input  logic [2:0]  FC,
   input  logic [22:0] ADDR,
   input  logic        nDTACK_ext,
   output logic        nDTACK_cpu,
   output logic        nVPA,
   output logic        nBERR,
   output logic        iack_strobe,
   output logic [2:0]  iack_level,
   output logic        berr_strobe
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam int RW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam int BW = (BERR_TIMEOUT > 0) ? $clog2(BERR_TIMEOUT + 1) : 1;

   typedef enum logic {S_IDLE, S_ACTIVE} bus_state_t;

   bus_state_t    state_q, state_d;
   logic [1:0]    rst_sync_q, rst_sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] rst_cnt_q, rst_cnt_d;
   logic          cpu_reset_q, cpu_reset_d;
   logic          iack_q, iack_d;
   logic          vpa_q, vpa_d;
   logic          berr_q, berr_d;
   logic [7:0]    wait_q, wait_d;
   logic [BW-1:0] wd_q, wd_d;
   logic          iack_strobe_q, iack_strobe_d;
   logic [2:0]    iack_level_q, iack_level_d;
   logic          berr_strobe_q, berr_strobe_d;

   logic run, active, is_iack, iack_blk, wait_met, dtack_on, vpa_on, berr_on, term;
   logic addr_unused;

   assign addr_unused = ^{ADDR[22:20], ADDR[15:4], ADDR[0]};

   assign run      = rst_sync_q[1];
   assign en_phi2  = run && (cnt_q == CW'(CLK_DIV/2 - 1));
   assign en_phi1  = run && (cnt_q == CW'(CLK_DIV - 1));
   assign active   = (state_q == S_ACTIVE);
   assign is_iack  = (FC == 3'b111) && (ADDR[19:16] == 4'hF);
   assign iack_blk = (AUTOVEC != 0) && iack_q;
   assign wait_met = int'(wait_q) >= DTACK_WAIT;

   // Terminations are qualified by nAS so they drop in the same clk the strobe rises.
   assign dtack_on = active && !nAS && !iack_blk && wait_met && !nDTACK_ext;
   assign vpa_on   = active && !nAS && vpa_q;
   assign berr_on  = active && !nAS && berr_q;
   assign term     = dtack_on || vpa_on || berr_on;

   assign nDTACK_cpu  = !dtack_on;
   assign nVPA        = !vpa_on;
   assign nBERR       = !berr_on;
   assign cpu_reset   = cpu_reset_q;
   assign iack_strobe = iack_strobe_q;
   assign iack_level  = iack_level_q;
   assign berr_strobe = berr_strobe_q;

   always_comb begin
      state_d       = state_q;
      rst_sync_d    = {rst_sync_q[0], 1'b1};
      cnt_d         = cnt_q;
      rst_cnt_d     = rst_cnt_q;
      cpu_reset_d   = cpu_reset_q;
      iack_d        = iack_q;
      vpa_d         = vpa_q;
      berr_d        = berr_q;
      wait_d        = wait_q;
      wd_d          = wd_q;
      iack_strobe_d = 1'b0;
      iack_level_d  = iack_level_q;
      berr_strobe_d = 1'b0;

      if (run) begin
         cnt_d = (cnt_q == CW'(CLK_DIV - 1)) ? '0 : cnt_q + CW'(1);
      end

      if (en_phi2 && cpu_reset_q) begin
         if (rst_cnt_q == RW'(RST_HOLD - 1)) begin
            cpu_reset_d = 1'b0;
         end else begin
            rst_cnt_d = rst_cnt_q + RW'(1);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (en_phi2 && !nAS) begin
               state_d = S_ACTIVE;
               wait_d  = '0;
               wd_d    = '0;
               vpa_d   = 1'b0;
               berr_d  = 1'b0;
               iack_d  = is_iack;
               if (is_iack) begin
                  iack_strobe_d = 1'b1;
                  iack_level_d  = ADDR[3:1];
               end
            end
         end
         S_ACTIVE: begin
            if (nAS) begin
               state_d = S_IDLE;
               wait_d  = '0;
               wd_d    = '0;
               iack_d  = 1'b0;
               vpa_d   = 1'b0;
               berr_d  = 1'b0;
            end else if (en_phi2) begin
               if (wait_q != '1) begin
                  wait_d = wait_q + 8'd1;
               end
               if (iack_blk) begin
                  vpa_d = 1'b1;
               end
               // A termination seen on the timeout edge suppresses the BERR.
               if ((BERR_TIMEOUT != 0) && !term) begin
                  wd_d = wd_q + BW'(1);
                  if (wd_q == BW'(BERR_TIMEOUT - 1)) begin
                     berr_d        = 1'b1;
                     berr_strobe_d = 1'b1;
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q       <= S_IDLE;
         rst_sync_q    <= '0;
         cnt_q         <= '0;
         rst_cnt_q     <= '0;
         cpu_reset_q   <= 1'b1;
         iack_q        <= 1'b0;
         vpa_q         <= 1'b0;
         berr_q        <= 1'b0;
         wait_q        <= '0;
         wd_q          <= '0;
         iack_strobe_q <= 1'b0;
         iack_level_q  <= '0;
         berr_strobe_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         rst_sync_q    <= rst_sync_d;
         cnt_q         <= cnt_d;
         rst_cnt_q     <= rst_cnt_d;
         cpu_reset_q   <= cpu_reset_d;
         iack_q        <= iack_d;
         vpa_q         <= vpa_d;
         berr_q        <= berr_d;
         wait_q        <= wait_d;
         wd_q          <= wd_d;
         iack_strobe_q <= iack_strobe_d;
         iack_level_q  <= iack_level_d;
         berr_strobe_q <= berr_strobe_d;
      end
   end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Bench for m68k_bus_ctrl: startup vector table, hand-written corner sequences and a
// randomized bus-cycle phase checked every clk against a behavioural model.
module tb_m68k_bus_ctrl;

   localparam int CLK_DIV      = 4;
   localparam int RST_HOLD     = 16;
   localparam int DTACK_WAIT   = 2;
   localparam int AUTOVEC      = 1;
   localparam int BERR_TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        nRESET = 1'b0;
   logic        nAS = 1'b1;
   logic [2:0]  FC = 3'd0;
   logic [22:0] ADDR = '0;
   logic        nDTACK_ext = 1'b1;
   logic        en_phi1, en_phi2, cpu_reset, nDTACK_cpu, nVPA, nBERR;
   logic        iack_strobe, berr_strobe;
   logic [2:0]  iack_level;

   int checks = 0;
   int errors = 0;

   m68k_bus_ctrl #(
      .CLK_DIV(CLK_DIV), .RST_HOLD(RST_HOLD), .DTACK_WAIT(DTACK_WAIT),
      .AUTOVEC(AUTOVEC), .BERR_TIMEOUT(BERR_TIMEOUT)
   ) dut (
      .clk(clk), .nRESET(nRESET), .en_phi1(en_phi1), .en_phi2(en_phi2),
      .cpu_reset(cpu_reset), .nAS(nAS), .FC(FC), .ADDR(ADDR),
      .nDTACK_ext(nDTACK_ext), .nDTACK_cpu(nDTACK_cpu), .nVPA(nVPA), .nBERR(nBERR),
      .iack_strobe(iack_strobe), .iack_level(iack_level), .berr_strobe(berr_strobe)
   );

   always #5 clk = ~clk;

   // Reference model: edges since release, phi2 edges seen, and bus-cycle bookkeeping.
   int       m_rel, m_phi2_seen, m_wait, m_idle;
   bit       m_in, m_iack, m_vpa, m_berr, m_istb, m_bstb;
   logic [2:0] m_lvl;

   function automatic bit exp_phi2();
      return (m_rel >= 2) && (((m_rel - 2) % CLK_DIV) == CLK_DIV/2 - 1);
   endfunction
   function automatic bit exp_phi1();
      return (m_rel >= 2) && (((m_rel - 2) % CLK_DIV) == CLK_DIV - 1);
   endfunction
   function automatic bit exp_dtack_n();
      return !(m_in && !nAS && !(AUTOVEC != 0 && m_iack) && m_wait >= DTACK_WAIT && !nDTACK_ext);
   endfunction
   function automatic bit exp_vpa_n();
      return !(m_in && !nAS && m_vpa);
   endfunction
   function automatic bit exp_berr_n();
      return !(m_in && !nAS && m_berr);
   endfunction

   task automatic model_reset();
      m_rel = 0; m_phi2_seen = 0; m_wait = 0; m_idle = 0;
      m_in = 0; m_iack = 0; m_vpa = 0; m_berr = 0; m_istb = 0; m_bstb = 0; m_lvl = 3'd0;
   endtask

   task automatic model_edge();
      bit e2, term;
      e2   = exp_phi2();
      term = !exp_dtack_n() || !exp_vpa_n() || !exp_berr_n();
      m_istb = 0;
      m_bstb = 0;
      if (!nRESET) begin
         model_reset();
         return;
      end
      if (e2 && m_phi2_seen < 100000) m_phi2_seen++;
      if (m_rel < 1000000) m_rel++;
      if (m_in) begin
         if (nAS) begin
            m_in = 0; m_iack = 0; m_vpa = 0; m_berr = 0; m_wait = 0; m_idle = 0;
         end else if (e2) begin
            if (AUTOVEC != 0 && m_iack) m_vpa = 1;
            if (!term && BERR_TIMEOUT > 0 && m_idle < BERR_TIMEOUT) begin
               m_idle++;
               if (m_idle == BERR_TIMEOUT) begin
                  m_berr = 1;
                  m_bstb = 1;
               end
            end
            if (m_wait < 255) m_wait++;
         end
      end else if (e2 && !nAS) begin
         m_in = 1; m_wait = 0; m_idle = 0; m_vpa = 0; m_berr = 0;
         m_iack = (FC == 3'd7) && (ADDR[19:16] == 4'hF);
         if (m_iack) begin
            m_lvl  = ADDR[3:1];
            m_istb = 1;
         end
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      logic [10:0] act, exp;
      act = {en_phi1, en_phi2, cpu_reset, nDTACK_cpu, nVPA, nBERR, iack_strobe, berr_strobe, iack_level};
      exp = {exp_phi1(), exp_phi2(), (m_phi2_seen < RST_HOLD), exp_dtack_n(), exp_vpa_n(),
             exp_berr_n(), m_istb, m_bstb, m_lvl};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL model {phi1,phi2,rst,dtack_n,vpa_n,berr_n,istb,bstb,lvl}: got %b expected %b at %0t",
                  act, exp, $time);
      end
   endtask

   // Inputs are driven at the falling edge; the model advances with them, then outputs are compared.
   task automatic tick();
      model_edge();
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic wait_phi2();
      for (int i = 0; i < 2*CLK_DIV + 2; i++) begin
         if (en_phi2) return;
         tick();
      end
      checks++;
      errors++;
      $display("FAIL wait_phi2: got no en_phi2 expected one within %0d clks", 2*CLK_DIV + 2);
   endtask

   // mode 0: plain timeout; 1: DTACK arrives on the timeout edge; 2: nAS rises on the timeout edge.
   task automatic berr_run(input int mode);
      int pulses;
      bit fired, e;
      wait_phi2();
      nAS = 1'b0; FC = 3'd5; ADDR = 23'h012340; nDTACK_ext = 1'b1;
      tick();
      pulses = 0;
      fired  = 0;
      for (int i = 0; i < 100; i++) begin
         if (en_phi2 && pulses == BERR_TIMEOUT - 1 && mode != 0) begin
            if (mode == 1) nDTACK_ext = 1'b0;
            else           nAS = 1'b1;
         end
         e = en_phi2;
         tick();
         if (e) pulses++;
         if (!nBERR || berr_strobe) begin
            fired = 1;
            break;
         end
         if (pulses >= BERR_TIMEOUT + 2) break;
      end
      if (mode == 0) begin
         chk("berr_pulses", pulses, BERR_TIMEOUT);
         chk("berr_strobe_hi", int'(berr_strobe), 1);
         tick();
         chk("berr_strobe_lo", int'(berr_strobe), 0);
         chk("berr_held", int'(nBERR), 0);
         nAS = 1'b1;
         #1;
         chk("berr_release", int'(nBERR), 1);
      end else begin
         chk($sformatf("berr_suppressed_mode%0d", mode), int'(fired), 0);
         if (mode == 1) chk("dtack_on_timeout", int'(nDTACK_cpu), 0);
         nAS = 1'b1;
      end
      nDTACK_ext = 1'b1;
      tick();
   endtask

   typedef struct {
      bit nas;
      bit ext;
      bit exp_phi1;
      bit exp_phi2;
      bit exp_rst;
      bit exp_dtack_n;
   } vec_t;

   vec_t tbl[12];
   int   p2;
   int   n;
   int   hold;
   int   rst_hold;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      // After release: 2 sync clks, then cnt 0,1(phi2),2,3(phi1),...; a cycle entered on the
      // first phi2 edge gets DTACK after two further phi2 edges.
      tbl[0]  = '{1, 1, 0, 0, 1, 1};
      tbl[1]  = '{1, 1, 0, 0, 1, 1};
      tbl[2]  = '{1, 1, 0, 1, 1, 1};
      tbl[3]  = '{0, 0, 0, 0, 1, 1};
      tbl[4]  = '{0, 0, 1, 0, 1, 1};
      tbl[5]  = '{0, 0, 0, 0, 1, 1};
      tbl[6]  = '{0, 0, 0, 1, 1, 1};
      tbl[7]  = '{0, 0, 0, 0, 1, 1};
      tbl[8]  = '{0, 0, 1, 0, 1, 1};
      tbl[9]  = '{0, 0, 0, 0, 1, 1};
      tbl[10] = '{0, 0, 0, 1, 1, 1};
      tbl[11] = '{0, 0, 0, 0, 1, 0};

      model_reset();
      @(negedge clk);
      check_model();
      nAS = 1'b0; nDTACK_ext = 1'b0; FC = 3'd7; ADDR = 23'h7FFFFF;
      repeat (3) tick();
      chk("reset_cpu_reset", int'(cpu_reset), 1);
      chk("reset_nVPA", int'(nVPA), 1);
      nAS = 1'b1; nDTACK_ext = 1'b1; FC = 3'd5; ADDR = 23'h000100;

      nRESET = 1'b1;
      p2 = 0;
      for (int i = 0; i < 12; i++) begin
         nAS = tbl[i].nas;
         nDTACK_ext = tbl[i].ext;
         tick();
         chk($sformatf("tbl%0d_phi1", i), int'(en_phi1), int'(tbl[i].exp_phi1));
         chk($sformatf("tbl%0d_phi2", i), int'(en_phi2), int'(tbl[i].exp_phi2));
         chk($sformatf("tbl%0d_rst", i), int'(cpu_reset), int'(tbl[i].exp_rst));
         chk($sformatf("tbl%0d_dtack_n", i), int'(nDTACK_cpu), int'(tbl[i].exp_dtack_n));
         if (en_phi2) p2++;
      end
      nAS = 1'b1;
      #1;
      chk("dtack_release_same_clk", int'(nDTACK_cpu), 1);
      nDTACK_ext = 1'b1;

      for (int i = 0; i < 400; i++) begin
         tick();
         if (!cpu_reset) break;
         if (en_phi2) p2++;
      end
      chk("cpu_reset_released", int'(cpu_reset), 0);
      chk("rst_hold_phi2_count", p2, RST_HOLD);

      berr_run(0);
      berr_run(1);
      berr_run(2);

      wait_phi2();
      nAS = 1'b0; FC = 3'd7; ADDR = 23'h7FFFF5; nDTACK_ext = 1'b0;
      tick();
      chk("iack_strobe_hi", int'(iack_strobe), 1);
      chk("iack_level", int'(iack_level), 2);
      chk("iack_vpa_not_yet", int'(nVPA), 1);
      chk("iack_no_dtack", int'(nDTACK_cpu), 1);
      tick();
      n = 1;
      chk("iack_strobe_lo", int'(iack_strobe), 0);
      while (nVPA && n < 20) begin
         chk("iack_dtack_wait", int'(nDTACK_cpu), 1);
         tick();
         n++;
      end
      chk("vpa_latency", n, CLK_DIV);
      repeat (3) begin
         tick();
         chk("vpa_held", int'(nVPA), 0);
         chk("iack_dtack_held", int'(nDTACK_cpu), 1);
      end

      #2 nRESET = 1'b0;
      #1;
      chk("midcycle_rst_cpu_reset", int'(cpu_reset), 1);
      chk("midcycle_rst_nVPA", int'(nVPA), 1);
      chk("midcycle_rst_nDTACK", int'(nDTACK_cpu), 1);
      chk("midcycle_rst_nBERR", int'(nBERR), 1);
      chk("midcycle_rst_enables", int'({en_phi1, en_phi2}), 0);
      chk("midcycle_rst_level", int'(iack_level), 0);
      model_reset();
      tick();
      nAS = 1'b1; nDTACK_ext = 1'b1;
      tick();
      nRESET = 1'b1;

      hold = 0;
      rst_hold = 0;
      for (int i = 0; i < 4000; i++) begin
         if (rst_hold > 0) begin
            rst_hold--;
            if (rst_hold == 0) nRESET = 1'b1;
         end else if ($urandom_range(0, 1499) == 0) begin
            nRESET = 1'b0;
            rst_hold = $urandom_range(1, 4);
         end
         if (hold > 0) begin
            hold--;
         end else if (nAS) begin
            if ($urandom_range(0, 3) == 0) begin
               nAS  = 1'b0;
               FC   = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
               ADDR = 23'($urandom());
               if ($urandom_range(0, 1) == 0) ADDR[19:16] = 4'hF;
               hold = $urandom_range(0, 60);
            end
         end else begin
            nAS  = 1'b1;
            hold = $urandom_range(0, 3);
         end
         if ($urandom_range(0, 9) == 0) nDTACK_ext = ~nDTACK_ext;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
